// File: rtl/riscv_pkg.sv
// Shared core-side types: retire trace record layout, sync byte and serialiser states.
package riscv_pkg;

  localparam logic [7:0] TRACE_SYNC = 8'hA5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wrt;
    logic [7:0]  seq;
    logic        lost;
  } trace_rec_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PC,
    INSTR,
    RDATA,
    MADDR,
    MDATA
  } trace_state_e;

  // Header: sync byte, sequence number, rd, store flag, loss tag, zero pad.
  function automatic logic [31:0] trace_header(input trace_rec_t rec);
    return {TRACE_SYNC, rec.seq, rec.reg_addr, rec.mem_wrt, rec.lost, 9'd0};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module trace_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  trace_rec_t               push_data,
  input  logic                     pop,
  output trace_rec_t               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  trace_rec_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; the count disambiguates full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/retire_trace_streamer.sv
// Buffers core retire records and serialises each into 4 or 6 words on a valid/ready stream.
module retire_trace_streamer
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   update_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        instr_i,
  input  logic [4:0]             reg_addr_i,
  input  logic [XLEN-1:0]        reg_data_i,
  input  logic [XLEN-1:0]        mem_addr_i,
  input  logic [XLEN-1:0]        mem_data_i,
  input  logic                   mem_wrt_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [31:0]            m_data_o,
  output logic                   m_last_o,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic [CNT_W-1:0]       drop_cnt_o
);

  trace_state_e state;
  trace_state_e nxt_state;
  trace_rec_t   rec;
  trace_rec_t   push_rec;
  trace_rec_t   head_rec;
  logic [7:0]   seq_q;
  logic         lost_q;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fire;
  logic         last_fire;
  logic         pop;
  logic         drop;

  function automatic trace_state_e next_state(input trace_state_e s, input logic wrt);
    case (s)
      HDR:     return PC;
      PC:      return INSTR;
      INSTR:   return RDATA;
      RDATA:   return wrt ? MADDR : IDLE;
      MADDR:   return MDATA;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [31:0] word_of(input trace_state_e s, input trace_rec_t r);
    case (s)
      HDR:     return trace_header(r);
      PC:      return r.pc;
      INSTR:   return r.instr;
      RDATA:   return r.reg_data;
      MADDR:   return r.mem_addr;
      MDATA:   return r.mem_data;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic is_last(input trace_state_e s, input logic wrt);
    return (s == RDATA && !wrt) || (s == MDATA);
  endfunction

  assign fire      = m_valid_o && m_ready_i;
  assign last_fire = fire && m_last_o;
  assign pop       = !fifo_empty && (state == IDLE || last_fire);
  assign drop      = update_i && fifo_full && !pop;
  assign nxt_state = next_state(state, rec.mem_wrt);

  always_comb begin
    push_rec          = '0;
    push_rec.pc       = pc_i;
    push_rec.instr    = instr_i;
    push_rec.reg_addr = reg_addr_i;
    push_rec.reg_data = reg_data_i;
    push_rec.mem_addr = mem_addr_i;
    push_rec.mem_data = mem_data_i;
    push_rec.mem_wrt  = mem_wrt_i;
    push_rec.seq      = seq_q;
    push_rec.lost     = lost_q;
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_i),
    .reset     (rst_i),
    .push      (update_i),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_level_o)
  );

  // seq counts every retire, dropped or not, so the host can see gaps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_q      <= '0;
      lost_q     <= 1'b0;
      drop_cnt_o <= '0;
    end else if (update_i) begin
      seq_q <= seq_q + 8'd1;
      if (drop) begin
        lost_q <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      end else begin
        lost_q <= 1'b0;
      end
    end
  end

  // Outputs are registered alongside the state so the word on the bus is stable until handshaken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rec       <= '0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
    end else if (pop) begin
      state     <= HDR;
      rec       <= head_rec;
      m_valid_o <= 1'b1;
      m_data_o  <= trace_header(head_rec);
      m_last_o  <= 1'b0;
    end else if (last_fire) begin
      state     <= IDLE;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
    end else if (fire) begin
      state    <= nxt_state;
      m_data_o <= word_of(nxt_state, rec);
      m_last_o <= is_last(nxt_state, rec.mem_wrt);
    end
  end

endmodule
